irq_pending_reg: RTL and testbench
==================================

Name: irq_pending_reg

Overview:
- Upstream request-capture stage for the 8-input priority encoder (devre4).
- Synchronises 8 asynchronous request lines and detects rising edges.
- Holds each event as a sticky pending bit until acknowledged, and applies a per-line enable mask.
- Drives the encoder's 8-bit input vector; the encoder's chosen index comes back on the ack port to clear the serviced bit.

Parameters:
- N, 8, number of request lines; must equal the encoder input width.
- IW, 3, acknowledge index width; equals clog2(N).
- SYNC_STAGES, 2, flip-flops in each input synchroniser; minimum 2.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_in  input  N  raw asynchronous request lines; an event is a 0->1 transition.
- mask_we  input  1  when 1, mask register loads mask_in.
- mask_in  input  N  new enable mask; 1 = line enabled.
- ack  input  1  one-cycle pulse: clear pending bit ack_idx.
- ack_idx  input  IW  index of the serviced line, taken from the encoder output.
- ovf_clr  input  1  when 1, clears all overflow bits.
- pend_o  output  N  pending AND mask; feeds the encoder input a[7:0].
- pend_raw  output  N  unmasked pending register.
- overflow  output  N  sticky per line: an event arrived while that line was already pending.
- irq  output  1  OR-reduction of pend_o.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - synchroniser flops, edge-history register, pending and overflow registers all go to 0.
  - mask register goes to all 1s.
  - Outputs while in reset: pend_o=0, pend_raw=0, overflow=0, irq=0.
- Synchroniser:
  - req_in[i] passes through SYNC_STAGES flops to give s[i].
  - prev[i] registers s[i].
  - edge[i] = s[i] & ~prev[i].
- Latency:
  - req_in rising before clock edge k is captured at edge k.
  - pend_raw[i] is visible after edge k+SYNC_STAGES, i.e. 3 edges in total for default parameters.
  - pend_o and irq are combinational from registers and add no extra cycle.
- Level held high produces exactly one event. Deasserting req_in does not clear pending.
- Pending update per bit i, per clock edge:
  - edge[i]=1: pend[i] <= 1. Set wins over a simultaneous ack of the same bit.
  - else if ack=1 and ack_idx==i: pend[i] <= 0.
  - else: hold.
- Overflow:
  - overflow[i] <= 1 when edge[i]=1, pend[i]=1, and bit i is not being acked in the same cycle.
  - If edge, ack of the same bit, and ovf_clr all occur in one cycle: pending stays 1 and overflow is not set.
  - ovf_clr=1 clears all overflow bits. A set condition in the same cycle wins for that bit.
- Mask:
  - mask_we=1 loads mask_in at the clock edge.
  - Masked lines still capture events into pend_raw; they are only hidden from pend_o and irq.
  - Re-enabling a line exposes an event that is already pending.
  - An ack to a masked line still clears its pend_raw bit.
- Ack index range: indices >= N are ignored (unreachable for N=8).
- Multiple edges in one cycle set all corresponding bits in parallel.
- Reset mid-operation:
  - All pending events and overflow bits are discarded.
  - prev is cleared, so a request line held high through reset release yields one fresh event SYNC_STAGES+1 edges after rst_n rises.
- No combinational path from req_in to any output.

Test Plan:
- Reset release, req_in=8'h00 for 10 cycles -> pend_o=8'h00, irq=0, overflow=8'h00, mask=8'hFF.
- req_in 8'h00->8'h81 then held -> pend_o=8'h81 exactly 3 edges later, irq=1; stays 8'h81 with no re-trigger while held.
- From pend=8'h81: ack=1, ack_idx=7 -> pend_o=8'h01 next cycle; then ack_idx=0 -> pend_o=8'h00, irq=0.
- Pulse req_in[2] twice with no ack in between -> pend_raw=8'h04, overflow=8'h04; ovf_clr=1 -> overflow=8'h00 and pend unchanged.
- Same cycle: edge on bit 5 and ack with ack_idx=5, bit 5 already pending -> pend_raw[5] stays 1, overflow[5] stays 0.
- mask_in=8'h0F with mask_we=1, then event on bit 6 -> pend_raw=8'h40, pend_o=8'h00, irq=0; mask=8'hFF -> pend_o=8'h40; assert rst_n=0 mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pending_if.sv
// Request/acknowledge bundle between the pending register and its consumer.
// master drives requests, mask and acks; slave is the pending register.
interface irq_pending_if #(
  parameter int N  = 8,
  parameter int IW = 3
);
  logic [N-1:0]  req_in;
  logic          mask_we;
  logic [N-1:0]  mask_in;
  logic          ack;
  logic [IW-1:0] ack_idx;
  logic          ovf_clr;
  logic [N-1:0]  pend_o;
  logic [N-1:0]  pend_raw;
  logic [N-1:0]  overflow;
  logic          irq;

  modport master (
    output req_in, mask_we, mask_in, ack, ack_idx, ovf_clr,
    input  pend_o, pend_raw, overflow, irq
  );

  modport slave (
    input  req_in, mask_we, mask_in, ack, ack_idx, ovf_clr,
    output pend_o, pend_raw, overflow, irq
  );
endinterface

// File: rtl/irq_pending_reg.sv
// Interrupt request capture: synchronise, detect rising edges, hold sticky
// pending bits until acked, track overflow and apply a per-line enable mask.
module irq_pending_reg #(
  parameter int N           = 8,
  parameter int IW          = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  irq_pending_if.slave  bus
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] prev_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] ovf_q;
  logic [N-1:0] mask_q;

  logic [N-1:0] s;
  logic [N-1:0] edge_det;
  logic [N-1:0] ack_hit;
  logic [N-1:0] pend_d;
  logic [N-1:0] ovf_set;
  logic [N-1:0] ovf_d;

  // NOTE: the synchroniser is a small flop array, not a RAM, so resetting
  // every stage is cheap and keeps a stale request from leaking out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value, giving a true shift chain regardless of order.
      sync_q[0] <= bus.req_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~prev_q;

  // Indices >= N never match any line, so out-of-range acks are ignored.
  always_comb begin
    // NOTE: default first so every bit is assigned on every path; no latch.
    ack_hit = '0;
    for (int i = 0; i < N; i++) begin
      ack_hit[i] = bus.ack && (bus.ack_idx == IW'(i));
    end
  end

  // A new edge beats an ack of the same bit; an edge that coincides with its
  // own ack is a fresh event, not an overflow.
  always_comb begin
    pend_d  = edge_det | (pend_q & ~ack_hit);
    ovf_set = edge_det & pend_q & ~ack_hit;
    ovf_d   = bus.ovf_clr ? ovf_set : (ovf_q | ovf_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      mask_q <= '1;
    end else begin
      prev_q <= s;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (bus.mask_we) mask_q <= bus.mask_in;
    end
  end

  assign bus.pend_raw = pend_q;
  assign bus.pend_o   = pend_q & mask_q;
  assign bus.overflow = ovf_q;
  assign bus.irq      = |(pend_q & mask_q);

endmodule

// File: tb/tb_irq_pending_reg.sv
// Directed bench for irq_pending_reg: latency, ack, overflow, mask and
// asynchronous reset behaviour with hand-computed expectations.
module tb_irq_pending_reg;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  irq_pending_if #(.N(8), .IW(3)) bus_if ();

  irq_pending_reg #(.N(8), .IW(3), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_if.req_in  = 8'h00;
    bus_if.mask_we = 1'b0;
    bus_if.mask_in = 8'h00;
    bus_if.ack     = 1'b0;
    bus_if.ack_idx = 3'd0;
    bus_if.ovf_clr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);

    check("rst_pend_o",   bus_if.pend_o,   8'h00);
    check("rst_pend_raw", bus_if.pend_raw, 8'h00);
    check("rst_overflow", bus_if.overflow, 8'h00);
    check("rst_irq",      {7'd0, bus_if.irq}, 8'h00);

    // Latency: three edges from request to pending; mask resets to all ones.
    bus_if.req_in = 8'h81;
    tick();
    check("lat_edge1", bus_if.pend_o, 8'h00);
    tick();
    check("lat_edge2", bus_if.pend_o, 8'h00);
    tick();
    check("lat_edge3", bus_if.pend_o, 8'h81);
    check("lat_irq",   {7'd0, bus_if.irq}, 8'h01);
    tick(5);
    check("held_pend_o",   bus_if.pend_o,   8'h81);
    check("held_overflow", bus_if.overflow, 8'h00);

    // Acks clear one bit each while the level is still held.
    bus_if.ack = 1'b1; bus_if.ack_idx = 3'd7;
    tick();
    bus_if.ack = 1'b0;
    check("ack7_pend_o", bus_if.pend_o, 8'h01);
    bus_if.ack = 1'b1; bus_if.ack_idx = 3'd0;
    tick();
    bus_if.ack = 1'b0;
    check("ack0_pend_o", bus_if.pend_o, 8'h00);
    check("ack0_irq",    {7'd0, bus_if.irq}, 8'h00);
    tick(3);
    check("held_no_retrig", bus_if.pend_raw, 8'h00);
    bus_if.req_in = 8'h00;
    tick(4);

    // Two pulses on bit 2 without ack: overflow.
    bus_if.req_in = 8'h04; tick(2);
    bus_if.req_in = 8'h00; tick(4);
    check("pulse1_pend_raw", bus_if.pend_raw, 8'h04);
    bus_if.req_in = 8'h04; tick(2);
    bus_if.req_in = 8'h00; tick(4);
    check("ovf_pend_raw", bus_if.pend_raw, 8'h04);
    check("ovf_overflow", bus_if.overflow, 8'h04);
    bus_if.ovf_clr = 1'b1;
    tick();
    bus_if.ovf_clr = 1'b0;
    check("ovfclr_overflow", bus_if.overflow, 8'h00);
    check("ovfclr_pend_raw", bus_if.pend_raw, 8'h04);

    // Bit 5 pending, then a new edge coinciding with its own ack.
    bus_if.req_in = 8'h20; tick(2);
    bus_if.req_in = 8'h00; tick(4);
    check("b5_pend_raw", bus_if.pend_raw, 8'h24);
    bus_if.req_in = 8'h20;
    tick(2);
    bus_if.ack = 1'b1; bus_if.ack_idx = 3'd5;
    tick();
    bus_if.ack = 1'b0;
    bus_if.req_in = 8'h00;
    check("edge_ack_pend_raw", bus_if.pend_raw, 8'h24);
    check("edge_ack_overflow", bus_if.overflow, 8'h00);
    tick(3);

    // Overflow set on bit 2 in the same cycle as ovf_clr: set wins.
    bus_if.req_in = 8'h04;
    tick(2);
    bus_if.ovf_clr = 1'b1;
    tick();
    bus_if.ovf_clr = 1'b0;
    bus_if.req_in = 8'h00;
    check("set_beats_clr", bus_if.overflow, 8'h04);
    tick(3);

    bus_if.ack = 1'b1; bus_if.ack_idx = 3'd2; tick();
    bus_if.ack_idx = 3'd5; tick();
    bus_if.ack = 1'b0;
    check("cleanup_pend_raw", bus_if.pend_raw, 8'h00);

    // Masked line still captures, and re-enabling exposes it.
    bus_if.mask_in = 8'h0F; bus_if.mask_we = 1'b1;
    tick();
    bus_if.mask_we = 1'b0;
    bus_if.req_in = 8'h40; tick(5);
    bus_if.req_in = 8'h00; tick(2);
    check("mask_pend_raw", bus_if.pend_raw, 8'h40);
    check("mask_pend_o",   bus_if.pend_o,   8'h00);
    check("mask_irq",      {7'd0, bus_if.irq}, 8'h00);
    bus_if.mask_in = 8'hFF; bus_if.mask_we = 1'b1;
    tick();
    bus_if.mask_we = 1'b0;
    check("unmask_pend_o", bus_if.pend_o, 8'h40);
    check("unmask_irq",    {7'd0, bus_if.irq}, 8'h01);
    check("pre_rst_overflow", bus_if.overflow, 8'h04);

    // Asynchronous reset mid-operation, no clock edge in between.
    bus_if.req_in = 8'h01;
    rst_n = 1'b0;
    #1;
    check("async_rst_pend_o",   bus_if.pend_o,   8'h00);
    check("async_rst_pend_raw", bus_if.pend_raw, 8'h00);
    check("async_rst_overflow", bus_if.overflow, 8'h00);
    check("async_rst_irq",      {7'd0, bus_if.irq}, 8'h00);
    tick(2);

    // Level held through reset release gives one fresh event three edges later.
    rst_n = 1'b1;
    tick(2);
    check("post_rst_edge2", bus_if.pend_raw, 8'h00);
    tick();
    check("post_rst_edge3", bus_if.pend_raw, 8'h01);
    tick(4);
    check("post_rst_held", bus_if.overflow, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
